// File: rtl/lvds_serdes_multilane.sv
// ---------------------------------------------------------------------------
// lvds_serdes_multilane
//   Multi-lane, single-clock serializer/deserializer with per-lane word
//   alignment on a reserved training pattern.
//
//   Tx: one LANES*DATA_WIDTH word is accepted per DATA_WIDTH-cycle frame.
//   Each lane shifts its slice out MSB-first at one bit per clock. When no
//   word is offered at a frame boundary the lane sends TRAIN_PATTERN.
//   Rx: every lane hunts for TRAIN_PATTERN independently, confirms it on
//   LOCK_COUNT consecutive frame boundaries, then delivers non-training
//   words with a one-cycle strobe.
//
// Ports
//   clk_sys        sole clock, serial bit rate
//   reset          synchronous, active-high
//   tx_data_in     per-lane tx slices, lane l = [l*DATA_WIDTH +: DATA_WIDTH]
//   tx_data_valid  tx word offered
//   tx_data_ready  word accepted this cycle (frame boundary, not in reset)
//   tx_lvds_out_p  serial out, positive leg (one bit per lane)
//   tx_lvds_out_n  serial out, negative leg (~tx_lvds_out_p)
//   rx_lvds_in_p   serial in, single-ended (one bit per lane)
//   loopback       1: lane l receives tx_lvds_out_p[l]
//   rx_realign     pulse, returns all lanes to SEARCH
//   rx_data_out    received per-lane words
//   rx_data_valid  per-lane one-cycle strobe for its slice
//   rx_locked      lane is framed and delivering data
// ---------------------------------------------------------------------------
module lvds_serdes_multilane #(
  parameter int unsigned          DATA_WIDTH    = 8,
  parameter int unsigned          LANES         = 2,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
  parameter int unsigned          LOCK_COUNT    = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [LANES*DATA_WIDTH-1:0]   tx_data_in,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic [LANES-1:0]              tx_lvds_out_p,
  output logic [LANES-1:0]              tx_lvds_out_n,
  input  logic [LANES-1:0]              rx_lvds_in_p,
  input  logic                          loopback,
  input  logic                          rx_realign,
  output logic [LANES*DATA_WIDTH-1:0]   rx_data_out,
  output logic [LANES-1:0]              rx_data_valid,
  output logic [LANES-1:0]              rx_locked
);

  localparam int unsigned    CW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned    MW     = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]  LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [MW-1:0]  LOCK_N = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } rx_state_e;

  // -------------------------------------------------------------------------
  // Tx: shared frame counter, per-lane shift registers
  // -------------------------------------------------------------------------
  logic [CW-1:0]                      bit_cnt_q, bit_cnt_d;
  logic                               tx_boundary;
  logic [LANES-1:0][DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;

  always_comb begin
    tx_boundary = (bit_cnt_q == LAST);
    bit_cnt_d   = tx_boundary ? '0 : bit_cnt_q + 1'b1;
    tx_sr_d     = tx_sr_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (tx_boundary) begin
        tx_sr_d[l] = tx_data_valid ? tx_data_in[l*DATA_WIDTH +: DATA_WIDTH]
                                   : TRAIN_PATTERN;
      end else begin
        tx_sr_d[l] = {tx_sr_q[l][DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt_q <= LAST;
      tx_sr_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
    end
  end

  // Ready is gated by reset so the source never sees an acceptance that the
  // reset is about to discard.
  assign tx_data_ready = tx_boundary & ~reset;

  always_comb begin
    tx_lvds_out_p = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      tx_lvds_out_p[l] = tx_sr_q[l][DATA_WIDTH-1];
    end
  end

  assign tx_lvds_out_n = ~tx_lvds_out_p;

  // -------------------------------------------------------------------------
  // Rx: one independent framer per lane
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic                    rx_bit;
    logic [DATA_WIDTH-2:0]   sr_q, sr_d;
    logic [DATA_WIDTH-1:0]   window;
    logic [CW-1:0]           phase_q, phase_d;
    logic [MW-1:0]           match_q, match_d, match_inc;
    rx_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    locked_q;
    logic                    rx_boundary;
    logic                    is_train;

    assign rx_bit      = loopback ? tx_lvds_out_p[g] : rx_lvds_in_p[g];
    // The window includes the bit arriving this cycle, so a word whose last
    // bit is on the wire now is judged now and strobed on the next cycle.
    assign window      = {sr_q, rx_bit};
    assign rx_boundary = (phase_q == LAST);
    assign is_train    = (window == TRAIN_PATTERN);
    assign match_inc   = match_q + 1'b1;

    always_comb begin
      sr_d    = window[DATA_WIDTH-2:0];
      phase_d = rx_boundary ? '0 : phase_q + 1'b1;
      match_d = match_q;
      state_d = state_q;
      data_d  = data_q;
      valid_d = 1'b0;
      // Realign overrides everything, including a SEARCH hit and a LOCKED
      // data strobe in the same cycle; the presented data is left untouched.
      if (rx_realign) begin
        state_d = SEARCH;
        match_d = '0;
      end else begin
        unique case (state_q)
          SEARCH: begin
            if (is_train) begin
              // Restart framing so the next boundary lands exactly one word
              // after this hit.
              phase_d = '0;
              match_d = MW'(1);
              state_d = VERIFY;
            end
          end
          VERIFY: begin
            if (rx_boundary) begin
              if (is_train) begin
                match_d = match_inc;
                if (match_inc == LOCK_N) state_d = LOCKED;
              end else begin
                match_d = '0;
                state_d = SEARCH;
              end
            end
          end
          LOCKED: begin
            if (rx_boundary && !is_train) begin
              data_d  = window;
              valid_d = 1'b1;
            end
          end
          default: begin
            state_d = SEARCH;
            match_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        sr_q     <= '0;
        phase_q  <= '0;
        match_q  <= '0;
        state_q  <= SEARCH;
        data_q   <= '0;
        valid_q  <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        sr_q     <= sr_d;
        phase_q  <= phase_d;
        match_q  <= match_d;
        state_q  <= state_d;
        data_q   <= data_d;
        valid_q  <= valid_d;
        locked_q <= (state_d == LOCKED);
      end
    end

    assign rx_data_out[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign rx_data_valid[g]                        = valid_q;
    assign rx_locked[g]                            = locked_q;
  end

endmodule

// File: tb/tb_lvds_serdes_multilane.sv
// ---------------------------------------------------------------------------
// tb_lvds_serdes_multilane
//   Self-checking bench. A behavioural model predicts the serial bit stream
//   of every tx lane from the accepted words, the frame boundaries from the
//   cycle count since reset, and the rx deliveries from the documented
//   latencies (accept + DATA_WIDTH + 1 in loopback, last bit + 1 otherwise).
// ---------------------------------------------------------------------------
module tb_lvds_serdes_multilane;

  localparam int         W  = 8;
  localparam int         L  = 2;
  localparam int         LC = 4;
  localparam logic [7:0] TP = 8'hF0;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic [L*W-1:0]   tx_data_in = '0;
  logic             tx_data_valid = 1'b0;
  logic             tx_data_ready;
  logic [L-1:0]     tx_lvds_out_p;
  logic [L-1:0]     tx_lvds_out_n;
  logic [L-1:0]     rx_lvds_in_p = '0;
  logic             loopback = 1'b1;
  logic             rx_realign = 1'b0;
  logic [L*W-1:0]   rx_data_out;
  logic [L-1:0]     rx_data_valid;
  logic [L-1:0]     rx_locked;

  always #5 clk_sys = ~clk_sys;

  lvds_serdes_multilane #(
    .DATA_WIDTH   (W),
    .LANES        (L),
    .TRAIN_PATTERN(TP),
    .LOCK_COUNT   (LC)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .tx_data_in   (tx_data_in),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .tx_lvds_out_p(tx_lvds_out_p),
    .tx_lvds_out_n(tx_lvds_out_n),
    .rx_lvds_in_p (rx_lvds_in_p),
    .loopback     (loopback),
    .rx_realign   (rx_realign),
    .rx_data_out  (rx_data_out),
    .rx_data_valid(rx_data_valid),
    .rx_locked    (rx_locked)
  );

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    bit         b;
    bit         last;
    logic [7:0] val;
  } sbit_t;

  bit         txq    [L][$];   // expected tx bits per lane
  exp_t       exprx  [L][$];   // expected rx deliveries per lane
  sbit_t      stream [L][$];   // external serial stimulus per lane
  logic [7:0] held   [L];      // last delivered rx word per lane

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int since    = 0;
  bit model_ok = 1'b0;
  bit accepted = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == TP);
    return b;
  endfunction

  task automatic push_word(input int l, input logic [7:0] w, input bit is_data);
    sbit_t s;
    for (int i = W - 1; i >= 0; i--) begin
      s.b    = w[i];
      s.last = is_data && (i == 0);
      s.val  = w;
      stream[l].push_back(s);
    end
  endtask

  task automatic push_zeros(input int l, input int n);
    sbit_t s;
    for (int i = 0; i < n; i++) begin
      s.b = 1'b0; s.last = 1'b0; s.val = '0;
      stream[l].push_back(s);
    end
  endtask

  // One clock cycle: inputs are already set by the caller (just after the
  // previous edge); outputs are checked, the model advances, then the edge.
  task automatic cycle();
    logic [L-1:0] drv;
    bit           bnd;
    bit           eb;
    bit           ev;
    sbit_t        s;
    exp_t         e;
    logic [7:0]   word;
    drv = '0;
    for (int l = 0; l < L; l++)
      if (stream[l].size() > 0) drv[l] = stream[l][0].b;
    rx_lvds_in_p = drv;
    #1;
    accepted = tx_data_ready && tx_data_valid;
    bnd = ((since % W) == 0);
    if (model_ok) begin
      check_eq("tx_ready", tx_data_ready, !reset && bnd);
      for (int l = 0; l < L; l++) begin
        eb = (txq[l].size() > 0) ? txq[l].pop_front() : 1'b0;
        check_eq("tx_p", tx_lvds_out_p[l], eb);
        check_eq("tx_n", tx_lvds_out_n[l], !eb);
        ev = 1'b0;
        if (exprx[l].size() > 0 && exprx[l][0].due == cyc) begin
          ev = 1'b1;
          held[l] = exprx[l][0].val;
          void'(exprx[l].pop_front());
        end
        check_eq("rx_valid", rx_data_valid[l], ev);
        check_eq("rx_data", rx_data_out[l*W +: W], held[l]);
      end
      if (!reset && bnd) begin
        for (int l = 0; l < L; l++) begin
          word = tx_data_valid ? tx_data_in[l*W +: W] : TP;
          for (int i = W - 1; i >= 0; i--) txq[l].push_back(word[i]);
          if (tx_data_valid && loopback) begin
            e.due = cyc + W + 1;
            e.val = word;
            exprx[l].push_back(e);
          end
        end
      end
    end
    for (int l = 0; l < L; l++) begin
      if (stream[l].size() > 0) begin
        s = stream[l].pop_front();
        if (s.last && !loopback && !reset) begin
          e.due = cyc + 1;
          e.val = s.val;
          exprx[l].push_back(e);
        end
      end
    end
    if (reset) begin
      for (int l = 0; l < L; l++) begin
        txq[l].delete();
        exprx[l].delete();
        held[l] = '0;
      end
      since    = 0;
      model_ok = 1'b1;
    end else begin
      since++;
    end
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic wait_locked(input logic [L-1:0] mask, input int budget,
                             input string tag);
    int n;
    n = 0;
    while (((rx_locked & mask) != mask) && (n < budget)) begin
      cycle();
      n++;
    end
    check_eq(tag, rx_locked & mask, mask);
  endtask

  task automatic send(input logic [L*W-1:0] w);
    int n;
    tx_data_valid = 1'b1;
    tx_data_in    = w;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n <= 2 * W);
    check_eq("tx_accept", accepted, 1'b1);
  endtask

  task automatic drain_streams();
    while (stream[0].size() > 0 || stream[1].size() > 0) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] d0, d1;
    @(posedge clk_sys);
    #1;

    // Reset, loopback idle: lanes lock on the training stream.
    reset = 1'b1; loopback = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    wait_locked(2'b11, (LC + 2) * W, "lock_initial");
    repeat (W) cycle();

    // Single word, then three back-to-back words.
    send(16'hA55A);
    send(16'h0102);
    send(16'h0304);
    send(16'h0506);
    tx_data_valid = 1'b0;
    repeat (2 * W) cycle();

    // Random words with random idle gaps.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 10)) cycle();
      send({rand_byte(), rand_byte()});
      if ($urandom_range(0, 1) == 0) tx_data_valid = 1'b0;
    end
    tx_data_valid = 1'b0;
    repeat (3 * W) cycle();

    // Realign while locked.
    rx_realign = 1'b1;
    cycle();
    rx_realign = 1'b0;
    check_eq("realign_unlock", rx_locked, 2'b00);
    wait_locked(2'b11, (LC + 2) * W, "realign_relock");
    repeat (2 * W) cycle();

    // External streams, lane0 skewed 3 bits behind lane1.
    d0 = rand_byte(); d1 = rand_byte();
    push_zeros(0, 2 * W + 3);
    push_zeros(1, 2 * W);
    for (int l = 0; l < L; l++) begin
      repeat (6) push_word(l, TP, 1'b0);
      push_word(l, (l == 0) ? d0 : d1, 1'b1);
      push_word(l, (l == 0) ? d1 : d0, 1'b1);
      repeat (2) push_word(l, TP, 1'b0);
    end
    loopback   = 1'b0;
    rx_realign = 1'b1;
    cycle();
    rx_realign = 1'b0;
    drain_streams();
    check_eq("skew_locked", rx_locked, 2'b11);

    // Corrupted second training word on lane0 during VERIFY.
    d0 = rand_byte(); d1 = rand_byte();
    push_zeros(0, 2 * W);
    push_zeros(1, 2 * W);
    push_word(0, TP, 1'b0);
    push_word(0, TP ^ 8'h01, 1'b0);
    repeat (6) push_word(0, TP, 1'b0);
    push_word(0, d0, 1'b1);
    push_word(0, TP, 1'b0);
    repeat (6) push_word(1, TP, 1'b0);
    push_word(1, d1, 1'b1);
    repeat (3) push_word(1, TP, 1'b0);
    rx_realign = 1'b1;
    cycle();
    rx_realign = 1'b0;
    wait_locked(2'b10, 8 * W, "flip_lane1_lock");
    check_eq("flip_lane0_unlocked", rx_locked[0], 1'b0);
    drain_streams();
    check_eq("flip_relock", rx_locked, 2'b11);

    // Back to loopback, then reset in the middle of a word.
    loopback   = 1'b1;
    rx_realign = 1'b1;
    cycle();
    rx_realign = 1'b0;
    wait_locked(2'b11, (LC + 2) * W, "loopback_relock");
    repeat (W) cycle();
    send({rand_byte(), rand_byte()});
    tx_data_valid = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    check_eq("reset_locked", rx_locked, 2'b00);
    check_eq("reset_rx_data", rx_data_out, 16'h0000);
    check_eq("reset_tx_p", tx_lvds_out_p, 2'b00);
    wait_locked(2'b11, (LC + 2) * W, "reset_relock");
    repeat (2 * W) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_serdes_multilane.md
Name: lvds_serdes_multilane

Overview:
- Multi-lane, single-clock LVDS serializer/deserializer with word alignment, and the successor to the single-lane 8:1 SerDes.
- Tx: one LANES*DATA_WIDTH word per handshake; each lane serializes its slice MSB-first at one bit per clock. The lane transmits TRAIN_PATTERN whenever no data is pending.
- Rx: each lane independently hunts for TRAIN_PATTERN, verifies it, locks word framing, then delivers data words and strips idle/training words.
- Internal loopback lets the block be brought up without external wiring.

Parameters:
- DATA_WIDTH, 8, bits per lane word (>=4).
- LANES, 2, number of independent serial lanes.
- TRAIN_PATTERN, 8'hF0, DATA_WIDTH-bit idle/alignment word. It is reserved and never sent as data. No nontrivial rotation of it may equal itself.
- LOCK_COUNT, 4, consecutive boundary-aligned pattern matches required to lock (>=2).

Ports:
- clk_sys  in  1  sole clock; serial bit rate = clk_sys.
- reset  in  1  synchronous, active-high reset.
- tx_data_in  in  LANES*DATA_WIDTH  lane l = bits [l*DATA_WIDTH +: DATA_WIDTH].
- tx_data_valid  in  1  tx word offered.
- tx_data_ready  out  1  block accepts tx_data_in this cycle.
- tx_lvds_out_p  out  LANES  serial output, positive leg.
- tx_lvds_out_n  out  LANES  always ~tx_lvds_out_p.
- rx_lvds_in_p  in  LANES  serial input, already single-ended.
- loopback  in  1  1: the rx input of lane l is tx_lvds_out_p[l].
- rx_realign  in  1  pulse; forces all lanes back to SEARCH.
- rx_data_out  out  LANES*DATA_WIDTH  received words, per-lane slices.
- rx_data_valid  out  LANES  per-lane 1-cycle strobe for its slice.
- rx_locked  out  LANES  lane is in LOCKED.

Behaviour:
- Reset values:
  - tx shift regs 0, so tx_lvds_out_p=0 and tx_lvds_out_n=all 1.
  - tx bit counter = DATA_WIDTH-1.
  - tx_data_ready=0.
  - rx_data_out=0, rx_data_valid=0, rx_locked=0.
  - All lanes in SEARCH; rx phase and match counters 0.
- Tx:
  - Shared bit counter 0..DATA_WIDTH-1. A word boundary occurs when the counter = DATA_WIDTH-1.
  - tx_data_ready = boundary && !reset, i.e. high for exactly 1 of every DATA_WIDTH cycles. The first cycle after reset is a boundary.
  - At a boundary: if tx_data_valid, load the tx_data_in slices; else load TRAIN_PATTERN into every lane.
  - Valid without ready is held by the source and is not consumed.
  - A word accepted at cycle t drives its MSB at t+1 and its LSB at t+DATA_WIDTH, so back-to-back words have no gap.
  - tx_lvds_out_p[l] = MSB of the lane l shift reg (registered). The shift is left by one each non-boundary cycle.
- Rx, per lane:
  - Input bit b = loopback ? tx_lvds_out_p[l] : rx_lvds_in_p[l].
  - sr <= {sr[W-2:0], b}; window = {sr[W-2:0], b}.
  - phase counts 0..W-1 and wraps. A boundary occurs when phase = W-1.
- Rx FSM, per lane:
  - SEARCH: checked every cycle. If window==TRAIN_PATTERN: phase<=0, match_cnt<=1, go to VERIFY.
  - VERIFY: checked at boundary only.
    - Match: match_cnt+1. If it reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: match_cnt<=0, go to SEARCH.
  - LOCKED: checked at boundary only.
    - window!=TRAIN_PATTERN: slice <= window and rx_data_valid[l]=1 for the next cycle only.
    - window==TRAIN_PATTERN: no strobe; the slice is held.
  - rx_realign: in any state, next cycle is SEARCH, match_cnt=0, rx_locked=0. Data already presented is held.
  - Simultaneous rx_realign and a SEARCH match: realign wins.
  - rx_locked[l] = (state==LOCKED), registered.
- Latency and independence:
  - Rx: last bit of a word on the input at cycle t gives rx_data_valid at t+1.
  - Loopback: accepted at t gives rx_data_valid at t+DATA_WIDTH+1.
  - Lanes are framed independently, so per-lane skew of any bit count is tolerated. No inter-lane deskew is performed.
- Reset mid-operation aborts the in-flight tx word (it is lost) and drops lock. All values return to reset state on the next edge.

Test Plan:
- Reset, loopback=1, no tx_data_valid -> each tx lane repeats 11110000. Both rx_locked rise within (LOCK_COUNT+2)*8 cycles; rx_data_valid stays 0.
- After lock, send 16'hA55A accepted at cycle t -> at t+9: rx_data_valid=2'b11, rx_data_out=16'hA55A, tx_lvds_out_n==~tx_lvds_out_p throughout.
- Hold tx_data_valid for words 16'h0102, 16'h0304, 16'h0506 -> tx_data_ready high every 8th cycle. All three are received in order on consecutive 8-cycle boundaries with no idle in between.
- loopback=0, lane0 fed the pattern+data stream delayed 3 bits vs lane1 -> both lanes lock and each slice equals the sent byte. Lane0's strobe trails lane1's by 3 cycles.
- During VERIFY, flip one bit of the 2nd pattern word -> lane returns to SEARCH and relocks later. Pulse rx_realign while locked -> rx_locked=0 next cycle, then relocks.
- Assert reset for 2 cycles mid-word -> all outputs at reset values, tx_data_ready=0 during reset and 1 on the first cycle after. The partial word is never delivered.
